// File: rtl/cache_pkg.sv
// Shared geometry, line layout and helpers for the two-way write-back cache.
package cache_pkg;

    localparam int ADDR_W     = 10;
    localparam int TAG_W      = 5;
    localparam int INDEX_W    = 1;
    localparam int WORD_OFF_W = 2;
    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 128;
    localparam int NUM_SETS   = 2;
    localparam int NUM_WAYS   = 2;
    localparam int NUM_LINES  = NUM_SETS * NUM_WAYS;
    localparam int MEM_IDX_W  = TAG_W + INDEX_W;
    localparam int MEM_BLOCKS = 64;

    // Address field positions
    localparam int OFF_LSB = 2;
    localparam int SET_LSB = OFF_LSB + WORD_OFF_W;
    localparam int TAG_LSB_A = SET_LSB + INDEX_W;

    // Line bit positions
    localparam int DATA_LSB  = 0;
    localparam int TAG_LSB   = 128;
    localparam int DIRTY_BIT = 133;
    localparam int VALID_BIT = 134;
    localparam int LINE_W    = 135;

    // Packed MSB-first, so field offsets match the line bit positions above.
    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_W-1:0]   tag;
        logic [BLOCK_W-1:0] data;
    } line_t;

    function automatic logic [BLOCK_W-1:0] merge_word(
        input logic [BLOCK_W-1:0]    blk,
        input logic [WORD_OFF_W-1:0] off,
        input logic [WORD_W-1:0]     word
    );
        logic [BLOCK_W-1:0] r;
        r = blk;
        r[off*WORD_W +: WORD_W] = word;
        return r;
    endfunction

endpackage

// File: rtl/main_memory.sv
// 64 x 128-bit backing store: combinational block read, write on the edge.
module main_memory
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MEM_IDX_W-1:0] rd_idx_i,
    output logic [BLOCK_W-1:0]   rd_data_o,
    input  logic                 we_i,
    input  logic [MEM_IDX_W-1:0] wr_idx_i,
    input  logic [BLOCK_W-1:0]   wr_data_i
);

    logic [BLOCK_W-1:0] Memory [MEM_BLOCKS];

    // Read sees pre-edge contents, so refill and write-back share one edge.
    assign rd_data_o = Memory[rd_idx_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_BLOCKS; i++) Memory[i] <= '0;
        end else if (we_i) begin
            Memory[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/cache_2way_wb.sv
// Two-way set-associative write-back/write-allocate cache with LRU and
// private main memory; every access completes in a single edge.
module cache_2way_wb
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               read_write,
    input  logic [ADDR_W-1:0]  address,
    input  logic [WORD_W-1:0]  write_data,
    output logic [BLOCK_W-1:0] read_data,
    output logic               hit
);

    line_t cache [NUM_LINES];
    logic  LRU   [NUM_SETS];

    logic [TAG_W-1:0]      req_tag;
    logic                  req_set;
    logic [WORD_OFF_W-1:0] req_off;
    logic                  unused_byte_off;

    assign req_tag         = address[ADDR_W-1:TAG_LSB_A];
    assign req_set         = address[SET_LSB];
    assign req_off         = address[SET_LSB-1:OFF_LSB];
    assign unused_byte_off = ^address[OFF_LSB-1:0];

    line_t                way_line [NUM_WAYS];
    logic [NUM_WAYS-1:0]  way_hit;
    logic                 hit_d;
    logic                 way_sel;
    line_t                victim;
    line_t                line_d;
    logic                 wb_en;
    logic [MEM_IDX_W-1:0] wb_idx;
    logic [MEM_IDX_W-1:0] rf_idx;
    logic [BLOCK_W-1:0]   mem_rdata;
    logic                 hit_q;
    logic [BLOCK_W-1:0]   rdata_q;

    assign rf_idx = address[ADDR_W-1:SET_LSB];

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_line[w] = cache[{w[0], req_set}];
            way_hit[w]  = way_line[w].valid && (way_line[w].tag == req_tag);
        end
        hit_d = |way_hit;

        // Hit way, else first invalid way, else the LRU way.
        if (hit_d)                   way_sel = way_hit[1];
        else if (!way_line[0].valid) way_sel = 1'b0;
        else if (!way_line[1].valid) way_sel = 1'b1;
        else                         way_sel = LRU[req_set];

        victim = way_line[way_sel];
        wb_en  = !hit_d && victim.valid && victim.dirty;
        wb_idx = {victim.tag, req_set};

        line_d.valid = 1'b1;
        line_d.tag   = req_tag;
        line_d.dirty = hit_d ? victim.dirty : 1'b0;
        line_d.data  = hit_d ? victim.data  : mem_rdata;
        if (read_write) begin
            line_d.data  = merge_word(line_d.data, req_off, write_data);
            line_d.dirty = 1'b1;
        end
    end

    main_memory memory (
        .clk       (clk),
        .reset     (reset),
        .rd_idx_i  (rf_idx),
        .rd_data_o (mem_rdata),
        .we_i      (wb_en),
        .wr_idx_i  (wb_idx),
        .wr_data_i (victim.data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) cache[i] <= '0;
            for (int s = 0; s < NUM_SETS; s++)  LRU[s]   <= 1'b0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cache[{way_sel, req_set}] <= line_d;
            LRU[req_set]              <= ~way_sel;
            hit_q                     <= hit_d;
            rdata_q                   <= line_d.data;
        end
    end

    assign hit       = hit_q;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_cache_2way_wb.sv
// Scoreboard bench for cache_2way_wb: directed scenarios plus a random
// back-to-back run against a flat golden memory with a tag/LRU tracker.
module tb_cache_2way_wb;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         read_write;
    logic [9:0]   address;
    logic [31:0]  write_data;
    logic [127:0] read_data;
    logic         hit;

    always #5 clk = ~clk;

    cache_2way_wb dut (
        .clk        (clk),
        .reset      (reset),
        .read_write (read_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         h;
        logic [127:0] d;
    } exp_t;
    exp_t sb[$];

    logic [127:0] gmem [64];
    logic         mv   [2][2];
    logic [4:0]   mt   [2][2];
    logic         mlru [2];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) gmem[i] = '0;
        for (int s = 0; s < 2; s++) begin
            mlru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0;
                mt[s][w] = '0;
            end
        end
    endtask

    task automatic model_access(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                                output logic eh, output logic [127:0] ed);
        logic         s, w, h0, h1;
        logic [4:0]   t;
        logic [1:0]   o;
        logic [127:0] blk;
        s  = a[4];
        t  = a[9:5];
        o  = a[3:2];
        h0 = mv[s][0] && (mt[s][0] == t);
        h1 = mv[s][1] && (mt[s][1] == t);
        eh = h0 | h1;
        if (h0)            w = 1'b0;
        else if (h1)       w = 1'b1;
        else if (!mv[s][0]) w = 1'b0;
        else if (!mv[s][1]) w = 1'b1;
        else               w = mlru[s];
        mv[s][w] = 1'b1;
        mt[s][w] = t;
        mlru[s]  = ~w;
        blk = gmem[a[9:4]];
        if (rw) begin
            blk[o*32 +: 32] = wd;
            gmem[a[9:4]] = blk;
        end
        ed = blk;
    endtask

    task automatic issue(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                         input logic eh, input logic [127:0] ed);
        exp_t e;
        read_write = rw;
        address    = a;
        write_data = wd;
        e.h = eh;
        e.d = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        exp_t e;
        reset      = 1'b1;
        read_write = 1'b1;
        address    = 10'h000;
        write_data = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (hit !== 1'b0 || read_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: hit=%b read_data=%h, need 0/0", hit, read_data);
        end
        checks++;
        if (dut.LRU[0] !== 1'b0 || dut.LRU[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_lru: %b%b, need 00", dut.LRU[1], dut.LRU[0]);
        end
        checks++;
        if (dut.memory.Memory[0] !== 128'h0) begin
            errors++;
            $display("FAIL reset_priority_mem0: %h, need 0", dut.memory.Memory[0]);
        end
        reset = 1'b0;
        model_reset();
        issue(1'b0, 10'h000, 32'h0, 1'b0, 128'h0);
        e = sb.pop_front();
        checks++;
        if (hit !== e.h || read_data !== e.d) begin
            errors++;
            $display("FAIL reset_first_read: hit=%b data=%h, need hit=%b data=%h", hit, read_data, e.h, e.d);
        end
        do_reset();
    endtask

    task automatic test_plan_set0();
        logic         rw_t  [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic [9:0]   a_t   [8] = '{10'h000, 10'h000, 10'h000, 10'h200, 10'h000, 10'h300, 10'h200, 10'h000};
        logic         eh_t  [8] = '{0, 1, 1, 0, 1, 0, 0, 0};
        logic [127:0] ed_t  [8] = '{128'h0, 128'hFF, 128'hFF, 128'h0, 128'hFF, 128'h0, 128'h0, 128'hFF};
        logic         lru_t [8] = '{1, 1, 1, 0, 1, 0, 1, 0};
        logic [127:0] m0_t  [8] = '{128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'hFF, 128'hFF};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(rw_t[i], a_t[i], 32'h0000_00FF, eh_t[i], ed_t[i]);
            e = sb.pop_front();
            checks++;
            if (hit !== e.h || read_data !== e.d) begin
                errors++;
                $display("FAIL plan_step%0d: hit=%b data=%h, need hit=%b data=%h", i + 1, hit, read_data, e.h, e.d);
            end
            checks++;
            if (dut.LRU[0] !== lru_t[i]) begin
                errors++;
                $display("FAIL plan_step%0d_lru0: %b, need %b", i + 1, dut.LRU[0], lru_t[i]);
            end
            checks++;
            if (dut.memory.Memory[0] !== m0_t[i]) begin
                errors++;
                $display("FAIL plan_step%0d_mem0: %h, need %h", i + 1, dut.memory.Memory[0], m0_t[i]);
            end
        end
    endtask

    task automatic test_set1();
        logic [127:0] blk;
        exp_t e;
        blk = {32'h0, 32'hDEAD_BEEF, 64'h0};
        issue(1'b1, 10'h018, 32'hDEAD_BEEF, 1'b0, blk);
        issue(1'b0, 10'h018, 32'h0, 1'b1, blk);
        issue(1'b0, 10'h01C, 32'h0, 1'b1, blk);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            checks++;
            if (i == 2 && (hit !== e.h || read_data !== e.d)) begin
                errors++;
                $display("FAIL set1_access%0d: hit=%b data=%h, need hit=%b data=%h", i, hit, read_data, e.h, e.d);
            end
        end
        checks++;
        if (dut.LRU[0] !== 1'b0 || dut.LRU[1] !== 1'b1) begin
            errors++;
            $display("FAIL set1_lru: lru0=%b lru1=%b, need 0/1", dut.LRU[0], dut.LRU[1]);
        end
        checks++;
        if (dut.memory.Memory[1] !== 128'h0) begin
            errors++;
            $display("FAIL set1_no_writethrough: mem1=%h, need 0", dut.memory.Memory[1]);
        end
        issue(1'b0, 10'h000, 32'h0, 1'b1, 128'hFF);
        e = sb.pop_front();
        checks++;
        if (hit !== e.h || read_data !== e.d) begin
            errors++;
            $display("FAIL set1_set0_intact: hit=%b data=%h, need hit=%b data=%h", hit, read_data, e.h, e.d);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        issue(1'b1, 10'h000, 32'h0000_00FF, 1'b0, 128'hFF);
        e = sb.pop_front();
        checks++;
        if (hit !== e.h || read_data !== e.d) begin
            errors++;
            $display("FAIL rstmid_write: hit=%b data=%h, need hit=%b data=%h", hit, read_data, e.h, e.d);
        end
        do_reset();
        issue(1'b0, 10'h000, 32'h0, 1'b0, 128'h0);
        e = sb.pop_front();
        checks++;
        if (hit !== e.h || read_data !== e.d) begin
            errors++;
            $display("FAIL rstmid_read: hit=%b data=%h, need hit=%b data=%h", hit, read_data, e.h, e.d);
        end
        checks++;
        if (dut.memory.Memory[0] !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_mem0: %h, need 0", dut.memory.Memory[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic         rw, eh;
        logic [9:0]   a;
        logic [31:0]  wd;
        logic [127:0] ed;
        exp_t e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = {3'b000, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wd = $urandom;
            model_access(rw, a, wd, eh, ed);
            issue(rw, a, wd, eh, ed);
            e = sb.pop_front();
            checks++;
            if (hit !== e.h || read_data !== e.d) begin
                errors++;
                $display("FAIL b2b_%0d addr=%h rw=%b: hit=%b data=%h, need hit=%b data=%h",
                         i, a, rw, hit, read_data, e.h, e.d);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        read_write = 1'b0;
        address    = '0;
        write_data = '0;
        model_reset();
        test_reset();
        test_plan_set0();
        test_set1();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
